keypad_scan_decoder: RTL and testbench

- Input-side counterpart of the time-multiplexed 7-segment driver: scans a 4x4 matrix keypad (Pmod KYPD) by driving one column low at a time and reading the rows.
- Debounces presses over whole scan frames and delivers a 4-bit hex key code with a one-cycle valid pulse.
- Sits between the board keypad pins and user logic; its key_code can feed the hexto7segment/display path directly.

---
 rtl/keypad_scan_decoder_pkg.sv | 25 ++
 rtl/keypad_scan_decoder_if.sv | 25 ++
 rtl/keypad_scan_decoder_tick_gen.sv | 24 ++
 rtl/keypad_scan_decoder.sv | 153 +++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_decoder_pkg.sv
// Shared types and keymap for the 4x4 matrix keypad scanner.
// Keymap is indexed {row,col}, col 0 being the leftmost column.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } kp_class_t;

  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/keypad_scan_decoder_if.sv
// Keypad pins plus decoded key outputs.
// master: the scanner; slave: keypad/user side.
interface keypad_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row,
      output col,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output row,
      input  col,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scan_decoder_tick_gen.sv
// Column-step divider: one-clk tick every SCAN_DIV clks.
module keypad_tick_gen #(
   parameter int SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad column scanner with frame-based debounce and hex decode.
module keypad_scan_decoder
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic      clk,
   input  logic      reset,
   keypad_if.master  kp
);
   localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DW-1:0] DF_M1 = DW'(DEBOUNCE_FRAMES - 1);

   logic            tick;
   logic [3:0]      row_s1;
   logic [3:0]      row_s2;
   logic [1:0]      col_idx;
   logic [3:0][3:0] snap;
   logic [3:0][3:0] frame_snap;
   logic            frame_end;
   logic [4:0]      nkeys;
   logic [3:0]      k_sel;
   kp_class_t       cls;
   kp_state_t       state;
   logic [DW-1:0]   dcnt;
   logic [3:0]      cand;
   logic [3:0]      key_code;
   logic            key_valid;

   keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign kp.col       = ~(4'b0001 << col_idx);
   assign kp.key_code  = key_code;
   assign kp.key_valid = key_valid;
   assign kp.key_held  = (state == HELD) || (state == RELEASE_CHK);
   assign frame_end    = tick && (col_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         row_s1  <= 4'hF;
         row_s2  <= 4'hF;
         col_idx <= 2'd0;
         snap    <= '1;
      end else begin
         row_s1 <= kp.row;
         row_s2 <= row_s1;
         if (tick) begin
            snap[col_idx] <= row_s2;
            col_idx       <= col_idx + 2'd1;
         end
      end
   end

   // Column 3 is classified from the live sample taken on this tick.
   always_comb begin
      frame_snap    = snap;
      frame_snap[3] = row_s2;
      nkeys         = '0;
      k_sel         = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!frame_snap[c][r]) begin
               nkeys = nkeys + 5'd1;
               k_sel = KEYMAP[{r[1:0], c[1:0]}];
            end
         end
      end
      if (nkeys == 5'd0)
         cls = NONE;
      else if (nkeys == 5'd1)
         cls = SINGLE;
      else
         cls = MULTI;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         dcnt      <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (frame_end) begin
            case (state)
               IDLE: begin
                  if (cls == SINGLE) begin
                     if (DEBOUNCE_FRAMES == 1) begin
                        state     <= HELD;
                        key_code  <= k_sel;
                        key_valid <= 1'b1;
                        dcnt      <= '0;
                     end else begin
                        state <= PRESS_CHK;
                        cand  <= k_sel;
                        dcnt  <= DW'(1);
                     end
                  end
               end
               PRESS_CHK: begin
                  if (cls == SINGLE && k_sel == cand) begin
                     if (dcnt == DF_M1) begin
                        state     <= HELD;
                        key_code  <= cand;
                        key_valid <= 1'b1;
                        dcnt      <= '0;
                     end else begin
                        dcnt <= dcnt + 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                     dcnt  <= '0;
                  end
               end
               HELD: begin
                  if (cls == NONE) begin
                     if (DEBOUNCE_FRAMES == 1) begin
                        state <= IDLE;
                        dcnt  <= '0;
                     end else begin
                        state <= RELEASE_CHK;
                        dcnt  <= DW'(1);
                     end
                  end
               end
               RELEASE_CHK: begin
                  if (cls == NONE) begin
                     if (dcnt == DF_M1) begin
                        state <= IDLE;
                        dcnt  <= '0;
                     end else begin
                        dcnt <= dcnt + 1'b1;
                     end
                  end else begin
                     state <= HELD;
                     dcnt  <= '0;
                  end
               end
               default: begin
                  state <= IDLE;
                  dcnt  <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench for keypad_scan_decoder with SCAN_DIV=4, DEBOUNCE_FRAMES=3.
module tb_keypad_scan_decoder;
   logic        clk;
   logic        reset;
   logic [15:0] pressed;

   int nvec;
   int nbad;
   int phase;

   keypad_if kp ();

   keypad_scan_decoder #(
      .SCAN_DIV        (4),
      .DEBOUNCE_FRAMES (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: row r is pulled low when a pressed key sits on a low column.
   always_comb begin
      kp.row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kp.col[c])
               kp.row[r] = 1'b0;
   end

   typedef struct {
      string       name;
      logic [15:0] keys;
      int          frames;
      int          pulses;
      logic [3:0]  code;
      logic        held;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(string n, logic [15:0] k, int f,
                               int p, logic [3:0] cd, logic h);
      vec_t v;
      v.name = n; v.keys = k; v.frames = f;
      v.pulses = p; v.code = cd; v.held = h;
      return v;
   endfunction

   task automatic check(string n, int act, int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0h, expected %0h", n, act, exp);
      end
   endtask

   task automatic run_frames(input int n, output int pulses,
                             output int col_err, output int back2back);
      logic prev;
      logic [3:0] exp_col;
      pulses = 0; col_err = 0; back2back = 0; prev = 1'b0;
      for (int i = 0; i < 16 * n; i++) begin
         @(posedge clk);
         phase++;
         @(negedge clk);
         exp_col = 4'hF;
         exp_col[(phase / 4) % 4] = 1'b0;
         if (kp.col != exp_col) col_err++;
         if (kp.key_valid) pulses++;
         if (kp.key_valid && prev) back2back++;
         prev = kp.key_valid;
      end
   endtask

   function automatic logic [15:0] key(int r, int c);
      logic [15:0] v;
      v = '0;
      v[r*4+c] = 1'b1;
      return v;
   endfunction

   initial begin
      int p, ce, bb, n;
      logic [15:0] k1, k2, kA, k7, kD, k5, k9, kE, k3;
      nvec = 0; nbad = 0; phase = 0;
      k1 = key(0, 0); k2 = key(0, 1); k3 = key(0, 2); kA = key(0, 3);
      k5 = key(1, 1); k7 = key(2, 0); k9 = key(2, 2);
      kE = key(3, 2); kD = key(3, 3);

      tv.push_back(mk("idle",        16'h0,   10, 0, 4'h0, 1'b0));
      tv.push_back(mk("5_f1_2",      k5,       2, 0, 4'h0, 1'b0));
      tv.push_back(mk("5_f3",        k5,       1, 1, 4'h5, 1'b1));
      tv.push_back(mk("5_hold",      k5,       3, 0, 4'h5, 1'b1));
      tv.push_back(mk("5_rel",       16'h0,    3, 0, 4'h5, 1'b0));
      tv.push_back(mk("D_short",     kD,       2, 0, 4'h5, 1'b0));
      tv.push_back(mk("D_gap",       16'h0,    1, 0, 4'h5, 1'b0));
      tv.push_back(mk("D_long",      kD,       5, 1, 4'hD, 1'b1));
      tv.push_back(mk("D_rel",       16'h0,    3, 0, 4'hD, 1'b0));
      tv.push_back(mk("A_press",     kA,       3, 1, 4'hA, 1'b1));
      tv.push_back(mk("A_plus_7",    kA | k7,  2, 0, 4'hA, 1'b1));
      tv.push_back(mk("7_only",      k7,       2, 0, 4'hA, 1'b1));
      tv.push_back(mk("all_rel",     16'h0,    3, 0, 4'hA, 1'b0));
      tv.push_back(mk("multi_1E",    k1 | kE,  5, 0, 4'hA, 1'b0));
      tv.push_back(mk("multi_rel",   16'h0,    1, 0, 4'hA, 1'b0));
      tv.push_back(mk("2_then",      k2,       2, 0, 4'hA, 1'b0));
      tv.push_back(mk("3_switch",    k3,       2, 0, 4'hA, 1'b0));
      tv.push_back(mk("3_accept",    k3,       2, 1, 4'h3, 1'b1));
      tv.push_back(mk("3_bounce",    16'h0,    2, 0, 4'h3, 1'b1));
      tv.push_back(mk("3_reheld",    k3,       1, 0, 4'h3, 1'b1));
      tv.push_back(mk("3_rel",       16'h0,    3, 0, 4'h3, 1'b0));

      pressed = '0;
      reset   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_col",   kp.col,       4'hE);
      check("rst_code",  kp.key_code,  4'h0);
      check("rst_valid", kp.key_valid, 0);
      check("rst_held",  kp.key_held,  0);
      reset = 1'b0;
      phase = 0;

      foreach (tv[i]) begin
         pressed = tv[i].keys;
         run_frames(tv[i].frames, p, ce, bb);
         check({tv[i].name, "_pulses"}, p, tv[i].pulses);
         check({tv[i].name, "_code"},   kp.key_code, tv[i].code);
         check({tv[i].name, "_held"},   kp.key_held, tv[i].held);
         check({tv[i].name, "_col"},    ce, 0);
         check({tv[i].name, "_b2b"},    bb, 0);
      end

      // Reset during the second PRESS_CHK frame of a held "9".
      pressed = k9;
      run_frames(1, p, ce, bb);
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_col",   kp.col,       4'hE);
      check("mid_rst_code",  kp.key_code,  4'h0);
      check("mid_rst_valid", kp.key_valid, 0);
      check("mid_rst_held",  kp.key_held,  0);
      reset = 1'b0;
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (kp.key_valid) break;
      end
      check("9_latency", n, 48);
      check("9_code",    kp.key_code, 4'h9);
      check("9_held",    kp.key_held, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
